spart_tx_unit: RTL and testbench
================================

// Module: spart_tx_unit
// PURPOSE
// Memory-mapped SPART transmitter directly downstream of the CPU MEM stage. Consumes the
// CPU's spart_wrt_en/spart_wrt_add/spart_wrt_data store stream (every store is presented),
// decodes its own addresses, buffers TX bytes in a FIFO and serialises them 8N1 on txd.
// The CPU has no stall input, so a store that finds the FIFO full is dropped and flagged.
// PARAMETERS
// TX_ADDR      32'h0000_FFF0  store here pushes wrt_data[7:0] into the TX FIFO
// DIV_ADDR     32'h0000_FFF4  store here loads baud divisor from wrt_data[15:0]
// STAT_ADDR    32'h0000_FFF8  store here with wrt_data[0]=1 clears the sticky overflow flag
// FIFO_DEPTH   8              TX FIFO entries; power of two, >= 2
// DEFAULT_DIV  16'd433        divisor after reset; bit period = divisor+1 clk cycles
// PORTS
// clk          in   1   clock
// rst          in   1   asynchronous, active-high reset
// wrt_en       in   1   store valid this cycle (from CPU EX/MEM register)
// wrt_add      in   32  store address
// wrt_data     in   32  store data
// txd          out  1   serial output, idle high
// tx_busy      out  1   1 while FSM not IDLE or FIFO non-empty
// fifo_full    out  1   FIFO holds FIFO_DEPTH entries
// fifo_count   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// overflow     out  1   sticky: a TX_ADDR store was dropped because FIFO was full
// BEHAVIOUR
// - Reset (async): txd=1, tx_busy=0, fifo_full=0, fifo_count=0, overflow=0, FSM=IDLE,
//   divisor=DEFAULT_DIV, FIFO pointers 0. Reset mid-frame aborts the frame, txd high at once.
// - Decode: exact 32-bit compare against each address; wrt_en with any other address ignored.
// - Push: wrt_en & addr==TX_ADDR & !fifo_full -> byte written, count+1 next edge.
//   If fifo_full: byte dropped, overflow<=1. A pop in the same cycle does NOT admit a push
//   into a full FIFO. Push and pop same cycle on non-full, non-empty FIFO: count unchanged.
// - Divisor: DIV_ADDR store updates divisor next edge; 0 is legal (1 cycle/bit). The FSM
//   latches the divisor into its own register on IDLE->START; a change mid-frame applies
//   to the next frame only.
// - STAT_ADDR store with wrt_data[0]=1 clears overflow; if a dropped push occurs in the same
//   cycle, set wins (overflow stays 1).
// - FSM: IDLE -> START when FIFO non-empty (pop head into shift reg, same edge).
//   START: txd=0 for one bit period -> DATA. DATA: 8 bits, LSB first, one bit period each,
//   3-bit bit index -> STOP after bit 7. STOP: txd=1 one bit period -> START if FIFO
//   non-empty (back-to-back, pop on that edge), else IDLE.
// - Bit timer: down-counter loaded with latched divisor at each bit start, bit ends on the
//   edge where counter==0. Frame length = 10*(divisor+1) cycles exactly.
// - Latency: store to empty FIFO with FSM IDLE in cycle N -> FIFO non-empty after edge N+1,
//   txd falls at edge N+2.
// - Pointer wrap: log2(FIFO_DEPTH)-bit pointers wrap naturally; count kept separately.
// STRUCTURE
// - Shared header spart_defs.vh: address constants, FSM state encodings (IDLE/START/DATA/STOP).
// - Sub-module spart_tx_fifo: synchronous FIFO (push, pop, din[7:0], dout, full, empty, count),
//   async reset. Remaining logic (decode, divisor, FSM, timer, shifter) in spart_tx_unit.
// TESTING
// 1 Reset, DEFAULT_DIV: store 8'h55 to TX_ADDR -> txd low at N+2; frame 0,1,0,1,0,1,0,1,0,1
//   each 434 cycles; then IDLE, tx_busy=0.
// 2 DIV_ADDR<=3, push 8'hA5,8'h3C -> two back-to-back frames, 40 cycles each, no idle gap.
// 3 DIV_ADDR<=0, push 9 bytes in consecutive cycles while idle -> 9 accepted (one popped
//   early), then fill to full; one more push -> dropped, overflow=1, fifo_full=1.
// 4 STAT_ADDR store 32'h1 -> overflow cleared; simultaneous dropped push -> overflow stays 1.
// 5 Mid-frame DIV_ADDR change 3->7 -> current frame keeps 4-cycle bits, next uses 8.
// 6 Assert rst in DATA state -> txd=1, fifo_count=0, divisor=DEFAULT_DIV; stores to
//   unrelated addresses never change fifo_count.

Source files
------------

// File: rtl/spart_tx_unit_pkg.sv
// Shared constants and types for the SPART transmitter:
// register addresses, FIFO sizing and the serialiser FSM states.
package spart_tx_unit_pkg;

  localparam logic [31:0] SPART_TX_ADDR   = 32'h0000_FFF0;
  localparam logic [31:0] SPART_DIV_ADDR  = 32'h0000_FFF4;
  localparam logic [31:0] SPART_STAT_ADDR = 32'h0000_FFF8;
  localparam int          SPART_FIFO_DEPTH = 8;
  localparam logic [15:0] SPART_DEFAULT_DIV = 16'd433;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/spart_tx_fifo.sv
// Synchronous byte FIFO for the SPART transmitter.
// A push into a full FIFO is refused even when a pop occurs in the same cycle.
module spart_tx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spart_tx_unit.sv
// Memory-mapped 8N1 SPART transmitter fed by the CPU store stream.
// Stores that hit a full FIFO are dropped and flagged in a sticky bit.
module spart_tx_unit
  import spart_tx_unit_pkg::*;
#(
  parameter logic [31:0] TX_ADDR     = SPART_TX_ADDR,
  parameter logic [31:0] DIV_ADDR    = SPART_DIV_ADDR,
  parameter logic [31:0] STAT_ADDR   = SPART_STAT_ADDR,
  parameter int          FIFO_DEPTH  = SPART_FIFO_DEPTH,
  parameter logic [15:0] DEFAULT_DIV = SPART_DEFAULT_DIV,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrt_en,
  input  logic [31:0]   wrt_add,
  input  logic [31:0]   wrt_data,
  output logic          txd,
  output logic          tx_busy,
  output logic          fifo_full,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  tx_state_t   state;
  tx_state_t   state_n;
  logic [15:0] divisor;
  logic [15:0] div_lat;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  head;
  logic        empty;
  logic        pop;
  logic        tick;
  logic        push_req;
  logic        push;
  logic        drop;
  logic        div_wr;
  logic        clr;
  logic        unused_data;

  assign unused_data = &{1'b0, wrt_data[31:16]};

  assign push_req = wrt_en & (wrt_add == TX_ADDR);
  assign push     = push_req & ~fifo_full;
  assign drop     = push_req & fifo_full;
  assign div_wr   = wrt_en & (wrt_add == DIV_ADDR);
  assign clr      = wrt_en & (wrt_add == STAT_ADDR) & wrt_data[0];
  assign tick     = (timer == '0);
  assign tx_busy  = (state != IDLE) | ~empty;

  spart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (wrt_data[7:0]),
    .dout (head),
    .full (fifo_full),
    .empty(empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor  <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (div_wr) divisor <= wrt_data[15:0];
      // a drop in the same cycle as a clear leaves the flag set
      if (drop)     overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_n = START;
          pop     = 1'b1;
        end
      end
      START: begin
        if (tick) state_n = DATA;
      end
      DATA: begin
        if (tick && bit_idx == 3'd7) state_n = STOP;
      end
      STOP: begin
        if (tick) begin
          if (!empty) begin
            state_n = START;
            pop     = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // each frame runs on the divisor captured when its byte was popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_lat <= DEFAULT_DIV;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (pop) begin
      div_lat <= divisor;
      timer   <= divisor;
      bit_idx <= '0;
      shreg   <= head;
    end else if (state != IDLE) begin
      if (tick) begin
        timer <= div_lat;
        if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        timer <= timer - 16'd1;
      end
    end
  end

  always_comb begin
    txd = 1'b1;
    unique case (state)
      START:   txd = 1'b0;
      DATA:    txd = shreg[0];
      default: txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_spart_tx_unit.sv
// Randomised bench for spart_tx_unit against a frame-timing reference model
// that predicts txd from frame start time, latched divisor and byte.
module tb_spart_tx_unit;
  import spart_tx_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        wrt_en;
  logic [31:0] wrt_add;
  logic [31:0] wrt_data;
  logic        txd;
  logic        tx_busy;
  logic        fifo_full;
  logic [3:0]  fifo_count;
  logic        overflow;

  int checks;
  int failures;
  bit chk_en;

  logic [7:0] mq[$];
  bit         busy_m;
  int         cyc;
  int         f_start;
  int         f_div;
  logic [7:0] f_byte;
  logic [15:0] div_m;
  bit         ovf_m;

  spart_tx_unit dut (
    .clk       (clk),
    .rst       (rst),
    .wrt_en    (wrt_en),
    .wrt_add   (wrt_add),
    .wrt_data  (wrt_data),
    .txd       (txd),
    .tx_busy   (tx_busy),
    .fifo_full (fifo_full),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_txd();
    int k;
    if (!busy_m) return 1'b1;
    k = (cyc - f_start) / (f_div + 1);
    if (k == 0) return 1'b0;
    if (k <= 8) return f_byte[k-1];
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int  pre;
    bit  fend;
    bit  drop;
    if (rst) begin
      mq.delete();
      busy_m = 0;
      div_m  = SPART_DEFAULT_DIV;
      ovf_m  = 0;
    end else begin
      cyc++;
      pre  = mq.size();
      drop = 0;
      fend = busy_m && ((cyc - f_start) == 10 * (f_div + 1));
      if ((!busy_m || fend) && pre > 0) begin
        f_byte  = mq.pop_front();
        f_start = cyc;
        f_div   = int'(div_m);
        busy_m  = 1;
      end else if (fend) begin
        busy_m = 0;
      end
      if (wrt_en && wrt_add == SPART_TX_ADDR) begin
        if (pre < SPART_FIFO_DEPTH) mq.push_back(wrt_data[7:0]);
        else drop = 1;
      end
      if (wrt_en && wrt_add == SPART_STAT_ADDR && wrt_data[0]) ovf_m = 0;
      if (drop) ovf_m = 1;
      if (wrt_en && wrt_add == SPART_DIV_ADDR) div_m = wrt_data[15:0];
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("txd", 32'(txd), 32'(exp_txd()));
      check("busy", 32'(tx_busy), 32'(busy_m || mq.size() > 0));
      check("full", 32'(fifo_full), 32'(mq.size() == SPART_FIFO_DEPTH));
      check("count", 32'(fifo_count), mq.size());
      check("ovf", 32'(overflow), 32'(ovf_m));
    end
  end

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    wrt_en   = 1'b1;
    wrt_add  = a;
    wrt_data = d;
    @(negedge clk);
    wrt_en   = 1'b0;
    wrt_add  = '0;
    wrt_data = '0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((tx_busy || busy_m || mq.size() > 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < limit), 32'd1);
  endtask

  task automatic reset_checks();
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    checks   = 0;
    failures = 0;
    chk_en   = 0;
    cyc      = 0;
    f_start  = 0;
    f_div    = 0;
    f_byte   = '0;
    busy_m   = 0;
    div_m    = SPART_DEFAULT_DIV;
    ovf_m    = 0;
    wrt_en   = 0;
    wrt_add  = '0;
    wrt_data = '0;
    rst      = 0;
    #1 rst = 1;
    #1 reset_checks();
    @(negedge clk);
    rst    = 0;
    chk_en = 1;

    put(SPART_TX_ADDR, 32'h55);
    wait_idle(5000);

    put(SPART_DIV_ADDR, 32'd3);
    put(SPART_TX_ADDR, 32'hA5);
    put(SPART_TX_ADDR, 32'h3C);
    wait_idle(200);

    put(SPART_DIV_ADDR, 32'd0);
    for (int i = 0; i < 9; i++) put(SPART_TX_ADDR, $urandom_range(0, 255));
    check("t3_full", 32'(fifo_full), 32'd1);
    put(SPART_TX_ADDR, 32'hEE);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_full2", 32'(fifo_full), 32'd1);
    put(SPART_STAT_ADDR, 32'h1);
    check("t4_clr", 32'(overflow), 32'd0);
    put(SPART_TX_ADDR, 32'h77);
    check("t4_popdrop", 32'(overflow), 32'd1);
    check("t4_count", 32'(fifo_count), 32'd7);
    put(SPART_STAT_ADDR, 32'h2);
    check("t4_noclr", 32'(overflow), 32'd1);
    put(SPART_STAT_ADDR, 32'h1);
    wait_idle(300);

    put(SPART_DIV_ADDR, 32'd3);
    put(SPART_TX_ADDR, 32'h96);
    put(SPART_TX_ADDR, 32'h0F);
    repeat (6) @(negedge clk);
    put(SPART_DIV_ADDR, 32'd7);
    wait_idle(300);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        put(SPART_TX_ADDR, $urandom);
      end else if (r == 5) begin
        put(SPART_DIV_ADDR, $urandom_range(0, 4));
      end else if (r == 6) begin
        put(SPART_STAT_ADDR, $urandom_range(0, 3));
      end else if (r == 7) begin
        a = $urandom;
        if (a == SPART_TX_ADDR || a == SPART_DIV_ADDR || a == SPART_STAT_ADDR)
          a = 32'h0000_FFF1;
        put(a, $urandom);
      end else begin
        @(negedge clk);
      end
    end
    wait_idle(3000);

    put(SPART_DIV_ADDR, 32'd3);
    put(SPART_TX_ADDR, 32'hC3);
    put(SPART_TX_ADDR, 32'h5A);
    put(32'h0000_FFF1, 32'h11);
    put(32'h0001_FFF0, 32'h22);
    put(32'h0000_FFFC, 32'h33);
    repeat (12) @(negedge clk);
    #2 rst = 1;
    #1 reset_checks();
    @(negedge clk);
    rst = 0;
    put(SPART_TX_ADDR, 32'h81);
    wait_idle(5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
